// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine and CPU/DMA external-bus arbiter: copies XFER_LEN bytes from {EFF,00} into OAM.
// Optional macro OAM_DMA_RESTART_EN: a DMA register write during a transfer restarts it.

module oam_dma_arbiter #(
   parameter int          XFER_LEN     = 160,
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        CPU_REQ,
   input  logic        CPU_WR,
   input  logic [15:0] CPU_ADDR,
   input  logic [7:0]  CPU_DOUT,
   output logic [7:0]  CPU_DIN,
   output logic [15:0] BUS_ADDR,
   output logic        BUS_RD,
   output logic        BUS_WR,
   output logic [7:0]  BUS_DOUT,
   input  logic [7:0]  BUS_DIN,
   output logic        OAM_WR,
   output logic [7:0]  OAM_ADDR,
   output logic [7:0]  OAM_DATA,
   output logic        DMA_ACTIVE,
   output logic [1:0]  o_dbg_state
);

   localparam int               IDX_W    = $clog2(XFER_LEN + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_START  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

   logic [1:0]       r_state;
   logic [7:0]       r_src;
   logic [7:0]       r_eff;
   logic [IDX_W-1:0] r_idx;
   logic             r_restart;
   logic             r_oam_wr;
   logic [7:0]       r_oam_addr;
   logic [7:0]       r_oam_data;

   logic       w_cpu_int;
   logic       w_cpu_reg;
   logic       w_reg_wr;
   logic       w_restart;
   logic       w_dma_active;
   logic       w_cpu_pass;
   logic       w_dma_step;
   logic [7:0] w_src_eff;
   logic [7:0] w_idx8;

   // CPU_REQ qualifies the access for this cycle only; there is no ready, the CPU is never stalled.
   assign w_cpu_int = (CPU_ADDR[15:8] == 8'hFF);
   assign w_cpu_reg = (CPU_ADDR == DMA_REG_ADDR);
   assign w_reg_wr  = CPU_REQ & CPU_WR & w_cpu_reg;

`ifdef OAM_DMA_RESTART_EN
   assign w_restart = w_reg_wr;
`else
   assign w_restart = 1'b0;
`endif

   assign w_dma_active = (r_state == ST_ACTIVE) | (r_state == ST_DRAIN) |
                         ((r_state == ST_START) & r_restart);
   assign w_cpu_pass   = CPU_REQ & ~w_cpu_reg & (w_cpu_int | ~w_dma_active);
   // An INT access that reaches the bus steals the cycle; the DMA index holds.
   assign w_dma_step   = (r_state == ST_ACTIVE) & ~w_cpu_pass;
   assign w_src_eff    = (r_src >= 8'hE0) ? (r_src - 8'h20) : r_src;
   assign w_idx8       = 8'(r_idx);

   always_comb begin
      BUS_ADDR = CPU_ADDR;
      BUS_DOUT = CPU_DOUT;
      BUS_RD   = w_cpu_pass & ~CPU_WR;
      BUS_WR   = w_cpu_pass & CPU_WR;
      if (w_dma_step) begin
         BUS_ADDR = {r_eff, w_idx8};
         BUS_RD   = 1'b1;
         BUS_WR   = 1'b0;
      end
      CPU_DIN = BUS_DIN;
      if (w_cpu_reg)
         CPU_DIN = r_src;
      else if (~w_cpu_int & w_dma_active)
         CPU_DIN = 8'hFF;
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         r_state    <= ST_IDLE;
         r_src      <= 8'h00;
         r_eff      <= 8'h00;
         r_idx      <= '0;
         r_restart  <= 1'b0;
         r_oam_wr   <= 1'b0;
         r_oam_addr <= 8'h00;
         r_oam_data <= 8'h00;
      end else begin
         if (w_reg_wr)
            r_src <= CPU_DOUT;
         r_oam_wr <= w_dma_step;
         if (w_dma_step) begin
            r_oam_addr <= w_idx8;
            r_oam_data <= BUS_DIN;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_reg_wr) begin
                  r_state   <= ST_START;
                  r_restart <= 1'b0;
               end
            end
            ST_START: begin
               // A further register write re-arms START so the latched source is always the newest.
               if (!w_reg_wr) begin
                  r_state   <= ST_ACTIVE;
                  r_idx     <= '0;
                  r_eff     <= w_src_eff;
                  r_restart <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (w_restart) begin
                  r_state   <= ST_START;
                  r_restart <= 1'b1;
               end else if (w_dma_step) begin
                  if (r_idx == IDX_LAST)
                     r_state <= ST_DRAIN;
                  else
                     r_idx <= r_idx + IDX_W'(1);
               end
            end
            ST_DRAIN: begin
               if (w_restart) begin
                  r_state   <= ST_START;
                  r_restart <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign OAM_WR      = r_oam_wr;
   assign OAM_ADDR    = r_oam_addr;
   assign OAM_DATA    = r_oam_data;
   assign DMA_ACTIVE  = w_dma_active;
   assign o_dbg_state = r_state;

endmodule
